// File: rtl/lut_sweep_pkg.sv
// Shared types and elaboration helpers for the exhaustive truth-table sweep checker.
// Latency: none (package only).
// Backpressure: none (package only).
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweepState_t;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 8;

  // True when the input count yields a truth table small enough to sweep.
  function automatic bit nInLegal(input int n);
    return (n >= N_IN_MIN) && (n <= N_IN_MAX);
  endfunction

  // Number of truth-table entries for an n-input function.
  function automatic int ttWidth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_sweep_checker_tt_bit_select.sv
// Combinational TT_W:1 mux returning one truth-table entry.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   tt     in  TT_W  truth table, bit i = entry for vector i
//   sel    in  N_IN  vector index
//   bitOut out 1     tt[sel]
module tt_bit_select
  import lut_sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TT_W = ttWidth(N_IN)
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] sel,
  output logic            bitOut
);

  assign bitOut = tt[sel];

endmodule

// File: rtl/lut_sweep_checker.sv
// Exhaustive sweep of an N_IN-input combinational DUT against a latched reference truth table.
// Latency: start-to-done is TT_W+1 cycles plus paused cycles; results hold until the next start.
// Backpressure: pause freezes the sweep with no compare; start outside IDLE is dropped, not queued.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start, pause     begin a sweep (IDLE only), hold the sweep (SWEEP only)
//   tt_ref           reference truth table, latched on the accepted start edge
//   dut_s            DUT response to vec, sampled at the closing edge of each compared cycle
//   vec, vec_valid   current input vector (MSB = first variable), compare-this-cycle flag
//   busy, done       SWEEP or DONE, one-cycle completion pulse
//   pass, err_count, first_err, first_err_valid   results of the last/current sweep
//   dut_tt           reconstructed DUT truth table (only when TT_CAPTURE_EN is defined)
// Build option: define TT_CAPTURE_EN to add the dut_tt capture register and port.
module lut_sweep_checker
  import lut_sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TT_W = ttWidth(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
  input  logic [TT_W-1:0] tt_ref,
  input  logic            dut_s,
  output logic [N_IN-1:0] vec,
  output logic            vec_valid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err,
  output logic            first_err_valid
`ifdef TT_CAPTURE_EN
  ,
  output logic [TT_W-1:0] dut_tt
`endif
);

  generate
    if (!nInLegal(N_IN) || (TT_W != ttWidth(N_IN))) begin : gBadParam
      $error("lut_sweep_checker: N_IN must be 1..8 and TT_W must equal 2**N_IN");
    end
  endgenerate

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TT_W - 1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  sweepState_t     stateQ;
  sweepState_t     nextState;
  logic [TT_W-1:0] ttQ;
  logic            refBit;
  logic            accept;
  logic            step;
  logic            mismatch;

  tt_bit_select #(
    .N_IN (N_IN),
    .TT_W (TT_W)
  ) uRefSel (
    .tt     (ttQ),
    .sel    (vec),
    .bitOut (refBit)
  );

  always_comb begin
    nextState = stateQ;
    accept    = 1'b0;
    step      = 1'b0;
    case (stateQ)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = SWEEP;
        end
      end
      SWEEP: begin
        if (!pause) begin
          step = 1'b1;
          if (vec == LAST_VEC) begin
            nextState = DONE;
          end
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign mismatch  = step && (dut_s != refBit);
  assign vec_valid = step;
  assign busy      = (stateQ != IDLE);
  assign done      = (stateQ == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ          <= IDLE;
      ttQ             <= '0;
      vec             <= '0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      stateQ <= nextState;
      if (accept) begin
        ttQ             <= tt_ref;
        vec             <= '0;
        err_count       <= '0;
        first_err       <= '0;
        first_err_valid <= 1'b0;
        pass            <= 1'b0;
      end else if (step) begin
        if (mismatch) begin
          err_count <= err_count + ERR_ONE;
          if (!first_err_valid) begin
            first_err       <= vec;
            first_err_valid <= 1'b1;
          end
        end
        // vec parks on the last entry so results and vec stay stable after DONE.
        if (vec != LAST_VEC) begin
          vec <= vec + VEC_ONE;
        end
      end else if (stateQ == DONE) begin
        pass <= (err_count == '0);
      end
    end
  end

`ifdef TT_CAPTURE_EN
  logic capBit;

  // Read the stored entry for vec and flip it only when the DUT disagrees,
  // so the write decode shares the same mux structure as the reference path.
  tt_bit_select #(
    .N_IN (N_IN),
    .TT_W (TT_W)
  ) uCapSel (
    .tt     (dut_tt),
    .sel    (vec),
    .bitOut (capBit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_tt <= '0;
    end else if (accept) begin
      dut_tt <= '0;
    end else if (step && (capBit != dut_s)) begin
      dut_tt <= dut_tt ^ (TT_W'(1) << vec);
    end
  end
`endif

endmodule
